load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits in the MEM stage between the EX/MEM pipeline register and the word-only data memory.
- Translates RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses on the data memory port.
- Because the memory has no byte enables, SB/SH are performed as a two-cycle read-modify-write, with the pipeline stalled for one cycle.
- Produces registered, extended load results for write-back, and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 32, width of the byte address.
- DATA_W, 32, data word width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_load  input  1  MEM-stage instruction is a load.
- req_store  input  1  MEM-stage instruction is a store.
- funct3  input  3  RV32I funct3 of the load/store.
- addr  input  ADDR_W  byte address from ALU.
- store_data  input  DATA_W  rs2 value, LSB-aligned.
- stall  output  1  combinational; holds IF..MEM stages this cycle.
- load_data  output  DATA_W  registered, extended load result.
- load_valid  output  1  registered; load_data valid this cycle.
- fault  output  1  registered one-cycle pulse: misaligned or illegal access.
- fault_addr  output  ADDR_W  registered address of the faulting access.
- mem_address  output  ADDR_W  word address to data memory; {addr[31:2],2'b00}.
- mem_write_data  output  DATA_W  word to write.
- mem_write  output  1  memory write enable.
- mem_read  output  1  memory read enable.
- mem_read_data  input  DATA_W  combinational read data from memory.

Behaviour:
- FSM states: IDLE, RMW_WR.
- Reset: state=IDLE; load_data=0, load_valid=0, fault=0, fault_addr=0, merge register=0.
- Reset gating: while reset=1, mem_write=0, mem_read=0 and stall=0 combinationally.
- A reset during RMW_WR aborts the write and returns the FSM to IDLE.

Classification (IDLE only; state changes and registered outputs update on the next edge):
- Illegal access: req_load & req_store both high, load funct3 in {3,6,7}, or store funct3 >2.
- Misaligned access: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
- Faulting access: no memory access; fault=1 and fault_addr=addr for exactly one cycle; load_valid=0.

Load (IDLE, legal):
- mem_read=1, stall=0.
- Selected lane (byte addr[1:0], half addr[1]) is sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes the word through.
- Result registered: load_data valid with load_valid=1 on the cycle after the request (1-cycle latency).

SW (IDLE, legal):
- mem_write=1, mem_write_data=store_data, stall=0, single cycle.

SB/SH (IDLE, legal):
- Cycle 0: mem_read=1, stall=1.
- Merge word = mem_read_data with lane(s) replaced by store_data[7:0] (SB) or store_data[15:0] (SH); merge word is registered; next state RMW_WR.
- Cycle 1 (RMW_WR): mem_write=1, mem_write_data=merge register, mem_read=0, stall=0; next state IDLE.
- Request inputs are ignored in RMW_WR; the pipeline still presents the same store, and it must not be re-issued.

Other rules:
- load_valid and fault are 0 in every cycle not following a load or faulting request.
- No request (req_load=req_store=0): all memory enables 0, stall=0.
- mem_address is driven from addr in IDLE and from the captured word address in RMW_WR.
- Back-to-back SB at the same word: the second read occurs after the first write has committed, so no hazard exists.

Test Plan:
- Mem word 0x100=0x8899AABB; LB addr 0x101 -> next cycle load_data=0xFFFFFFAA, load_valid=1; LBU addr 0x101 -> 0x000000AA.
- LH addr 0x102 -> 0xFFFF8899; LHU addr 0x102 -> 0x00008899; LW addr 0x100 -> 0x8899AABB.
- SB store_data=0x12345678 addr 0x103 -> stall=1 one cycle, then mem_write with 0x7899AABB; subsequent LW 0x100 returns 0x7899AABB.
- SH store_data=0xCAFE addr 0x100, followed by SB 0x55 addr 0x101 back-to-back -> final word 0x889955FE; exactly two stall cycles total.
- LW addr 0x102 and SH addr 0x201 -> fault pulses with fault_addr 0x102 then 0x201; mem_write/mem_read never asserted; load_valid=0.
- Assert reset during RMW_WR of SB to 0x100 -> mem_write never asserted; word unchanged; after reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage load/store translator between the EX/MEM pipeline register and a
// word-only data memory. Loads are read in a single cycle, then extended and
// registered. SW is a single-cycle write. The memory has no byte enables, so
// SB/SH are done as a two-cycle read-modify-write and stall the pipeline for
// one cycle.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_load/req_store  MEM-stage access request
//   funct3              RV32I width/sign selector
//   addr, store_data    byte address and LSB-aligned store value
//   stall               combinational pipeline hold (SB/SH read cycle)
//   load_data/valid     registered, extended load result
//   fault, fault_addr   registered one-cycle pulse for misaligned/illegal access
//   mem_*               word-addressed data memory port
//
// State table:
//   IDLE   | accept and classify requests; loads, SW, and the RMW read phase
//   RMW_WR | write the merged word captured during the RMW read phase
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] RMW_WR = 1'b1;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [DATA_W-1:0] merge_q;
   logic [DATA_W-1:0] merge_nxt;
   logic [DATA_W-1:0] load_ext;
   logic [ADDR_W-1:0] word_addr;
   logic [ADDR_W-1:0] word_addr_q;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic              illegal;
   logic              misaligned;
   logic              active;
   logic              in_rmw;
   logic              bad;
   logic              do_fault;
   logic              do_load;
   logic              do_sw;
   logic              do_rmw;

   assign word_addr = {addr[ADDR_W-1:2], 2'b00};

   // Requests are only looked at in IDLE and never while reset is high.
   assign active = ~reset & (state == IDLE);
   assign in_rmw = ~reset & (state == RMW_WR);

   always_comb begin
      illegal = 1'b0;
      if (req_load && req_store) begin
         illegal = 1'b1;
      end else if (req_load) begin
         case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
            default:                        illegal = 1'b1;
         endcase
      end else if (req_store) begin
         illegal = (funct3 > F3_W);
      end
   end

   // For stores, funct3 values above SW are already illegal, so the HU arm
   // only ever matters for loads.
   always_comb begin
      misaligned = 1'b0;
      case (funct3)
         F3_W:       misaligned = (addr[1:0] != 2'b00);
         F3_H, F3_HU: misaligned = addr[0];
         default:    misaligned = 1'b0;
      endcase
   end

   assign bad      = illegal | misaligned;
   assign do_fault = active & (req_load | req_store) & bad;
   assign do_load  = active & req_load & ~bad;
   assign do_sw    = active & req_store & ~bad & (funct3 == F3_W);
   assign do_rmw   = active & req_store & ~bad & (funct3 != F3_W);

   assign stall          = do_rmw;
   assign mem_read       = do_load | do_rmw;
   assign mem_write      = do_sw | in_rmw;
   assign mem_write_data = (state == RMW_WR) ? merge_q : store_data;
   assign mem_address    = (state == RMW_WR) ? word_addr_q : word_addr;

   always_comb begin
      byte_lane = mem_read_data[7:0];
      case (addr[1:0])
         2'd0: byte_lane = mem_read_data[7:0];
         2'd1: byte_lane = mem_read_data[15:8];
         2'd2: byte_lane = mem_read_data[23:16];
         2'd3: byte_lane = mem_read_data[31:24];
         default: byte_lane = mem_read_data[7:0];
      endcase
      half_lane = addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
   end

   always_comb begin
      load_ext = mem_read_data;
      case (funct3)
         F3_B:    load_ext = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   load_ext = {24'd0, byte_lane};
         F3_H:    load_ext = {{16{half_lane[15]}}, half_lane};
         F3_HU:   load_ext = {16'd0, half_lane};
         default: load_ext = mem_read_data;
      endcase
   end

   always_comb begin
      merge_nxt = mem_read_data;
      if (funct3 == F3_B) begin
         case (addr[1:0])
            2'd0: merge_nxt[7:0]   = store_data[7:0];
            2'd1: merge_nxt[15:8]  = store_data[7:0];
            2'd2: merge_nxt[23:16] = store_data[7:0];
            2'd3: merge_nxt[31:24] = store_data[7:0];
            default: merge_nxt = mem_read_data;
         endcase
      end else begin
         if (addr[1]) merge_nxt[31:16] = store_data[15:0];
         else         merge_nxt[15:0]  = store_data[15:0];
      end
   end

   // RMW_WR ignores the request lines: the pipeline still shows the same
   // store, which must not be issued a second time.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = do_rmw ? RMW_WR : IDLE;
         RMW_WR:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         load_data   <= '0;
         load_valid  <= 1'b0;
         fault       <= 1'b0;
         fault_addr  <= '0;
         merge_q     <= '0;
         word_addr_q <= '0;
      end else begin
         state      <= state_nxt;
         load_valid <= do_load;
         fault      <= do_fault;
         if (do_load) begin
            load_data <= load_ext;
         end
         if (do_fault) begin
            fault_addr <= addr;
         end
         if (do_rmw) begin
            merge_q     <= merge_nxt;
            word_addr_q <= word_addr;
         end
      end
   end

endmodule
